// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O port bank: port indices and
// the status-register field layout.
package io_pkg;

    localparam int unsigned DATA_W        = 32;

    localparam logic [1:0]  IOPORT_OUT0   = 2'd0;
    localparam logic [1:0]  IOPORT_OUT1   = 2'd1;
    localparam logic [1:0]  IOPORT_IN     = 2'd2;
    localparam logic [1:0]  IOPORT_STAT   = 2'd3;

    localparam int unsigned STAT_MASK_LSB = 16;

endpackage

// File: rtl/input_sync_edge.sv
// Multi-flop synchroniser for asynchronous input pins, followed by a one-cycle
// history register used to detect rising edges on the synchronised level.
module input_sync_edge #(
    parameter int unsigned W      = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] pins_i,
    output logic [W-1:0] level_o,
    output logic [W-1:0] rise_o
);

    logic [STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]             prev_q;

    // Synchroniser shift chain; stage 0 is the metastability-exposed flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pins_i};
        end
    end

    // History of the synchronised level; clearing it on reset makes a pin
    // that is already high at reset release show up as a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped I/O bank: two output registers, a synchronised input port,
// sticky rising-edge flags with W1C clear, an interrupt mask and a level irq.
module io_port_bank #(
    parameter int unsigned IN_WIDTH    = 8,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           ioport_we,
    input  logic [31:0]          wd,
    input  logic [1:0]           ioport_rd_sel,
    output logic [31:0]          rd,
    input  logic [IN_WIDTH-1:0]  in_pins,
    output logic [OUT_WIDTH-1:0] out0,
    output logic [OUT_WIDTH-1:0] out1,
    output logic                 irq
);

    import io_pkg::*;

    logic [OUT_WIDTH-1:0] out0_q, out0_d;
    logic [OUT_WIDTH-1:0] out1_q, out1_d;
    logic [IN_WIDTH-1:0]  flags_q, flags_d;
    logic [IN_WIDTH-1:0]  mask_q, mask_d;
    logic                 irq_q, irq_d;
    logic [IN_WIDTH-1:0]  level_s;
    logic [IN_WIDTH-1:0]  rise_s;
    logic [IN_WIDTH-1:0]  clr_s;
    logic                 unused_wd_s;

    input_sync_edge #(
        .W      (IN_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pins_i  (in_pins),
        .level_o (level_s),
        .rise_o  (rise_s)
    );

    // Next state for all registers; strobe bits are independent so a
    // multi-hot write updates every selected port together.
    always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        mask_d = mask_q;
        clr_s  = '0;
        if (ioport_we[IOPORT_OUT0]) begin
            out0_d = wd[OUT_WIDTH-1:0];
        end else begin
            out0_d = out0_q;
        end
        if (ioport_we[IOPORT_OUT1]) begin
            out1_d = wd[OUT_WIDTH-1:0];
        end else begin
            out1_d = out1_q;
        end
        if (ioport_we[IOPORT_STAT]) begin
            clr_s  = wd[IN_WIDTH-1:0];
            mask_d = wd[STAT_MASK_LSB +: IN_WIDTH];
        end else begin
            clr_s  = '0;
            mask_d = mask_q;
        end
        // A new rising edge wins over a W1C clear landing in the same cycle.
        flags_d = (flags_q & ~clr_s) | rise_s;
        irq_d   = |(flags_q & mask_q);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out0_q  <= '0;
            out1_q  <= '0;
            flags_q <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            flags_q <= flags_d;
            mask_q  <= mask_d;
            irq_q   <= irq_d;
        end
    end

    // Combinational read mux into the CPU load-data path.
    always_comb begin
        rd = 32'd0;
        case (ioport_rd_sel)
            IOPORT_OUT0: rd = DATA_W'(out0_q);
            IOPORT_OUT1: rd = DATA_W'(out1_q);
            IOPORT_IN:   rd = DATA_W'(level_s);
            IOPORT_STAT: rd = (DATA_W'(mask_q) << STAT_MASK_LSB) | DATA_W'(flags_q);
            default:     rd = 32'd0;
        endcase
    end

    assign unused_wd_s = ^wd;
    assign out0        = out0_q;
    assign out1        = out1_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank with hand-computed expectations.
module tb_io_port_bank;

    logic        clk;
    logic        reset_n;
    logic [3:0]  ioport_we;
    logic [31:0] wd;
    logic [1:0]  ioport_rd_sel;
    logic [31:0] rd;
    logic [7:0]  in_pins;
    logic [7:0]  out0;
    logic [7:0]  out1;
    logic        irq;

    int checks_cnt;
    int errors_cnt;

    io_port_bank #(
        .IN_WIDTH    (8),
        .OUT_WIDTH   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ioport_we     (ioport_we),
        .wd            (wd),
        .ioport_rd_sel (ioport_rd_sel),
        .rd            (rd),
        .in_pins       (in_pins),
        .out0          (out0),
        .out1          (out1),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout CHECKS %0d", checks_cnt);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input logic [1:0] sel, input string tag, input logic [31:0] exp);
        ioport_rd_sel = sel;
        #1;
        check(tag, rd, exp);
    endtask

    task automatic write(input logic [3:0] we, input logic [31:0] data);
        ioport_we = we;
        wd        = data;
        tick();
        ioport_we = 4'b0000;
        wd        = 32'd0;
    endtask

    initial begin
        checks_cnt    = 0;
        errors_cnt    = 0;
        reset_n       = 1'b0;
        ioport_we     = 4'b0000;
        wd            = 32'd0;
        ioport_rd_sel = 2'd0;
        in_pins       = 8'h00;

        // 1: reset state
        repeat (3) tick();
        check("rst_out0", 32'(out0), 32'd0);
        check("rst_out1", 32'(out1), 32'd0);
        check("rst_irq",  32'(irq),  32'd0);
        for (int s = 0; s < 4; s++) rd_check(2'(s), "rst_rd", 32'd0);
        reset_n = 1'b1;
        tick();

        // 2: output registers
        write(4'b0001, 32'h0000_00A5);
        write(4'b0010, 32'h0000_003C);
        check("out0", 32'(out0), 32'h0000_00A5);
        check("out1", 32'(out1), 32'h0000_003C);
        rd_check(2'd0, "rd_out0", 32'h0000_00A5);
        rd_check(2'd1, "rd_out1", 32'h0000_003C);
        write(4'b0111, 32'h1234_5678);
        check("multi_out0", 32'(out0), 32'h0000_0078);
        check("multi_out1", 32'(out1), 32'h0000_0078);
        rd_check(2'd2, "rd_in_ro", 32'd0);

        // 3: pin rise on bit 2, mask 0
        in_pins = 8'h04;
        tick();
        rd_check(2'd2, "sync_n", 32'd0);
        tick();
        rd_check(2'd2, "sync_n1", 32'h0000_0004);
        rd_check(2'd3, "flag_n1", 32'd0);
        tick();
        rd_check(2'd3, "flag_n2", 32'h0000_0004);
        tick();
        check("irq_masked", 32'(irq), 32'd0);

        // 4: unmask and clear
        write(4'b1000, 32'h0004_0000);
        rd_check(2'd3, "stat_mask", 32'h0004_0004);
        check("irq_pre", 32'(irq), 32'd0);
        tick();
        check("irq_set", 32'(irq), 32'd1);
        write(4'b1000, 32'h0004_0004);
        rd_check(2'd3, "stat_clr", 32'h0004_0000);
        check("irq_lag", 32'(irq), 32'd1);
        tick();
        check("irq_clr", 32'(irq), 32'd0);

        // 5: rise on pin 3 colliding with W1C of bit 3
        in_pins = 8'h0C;
        tick();
        tick();
        write(4'b1000, 32'h0004_0008);
        rd_check(2'd3, "collide", 32'h0004_0008);
        write(4'b1000, 32'h0004_0008);
        rd_check(2'd3, "w1c_bit3", 32'h0004_0000);
        check("irq_unmasked_bit", 32'(irq), 32'd0);

        // 6: async reset mid-run
        in_pins = 8'h00;
        repeat (3) tick();
        write(4'b1000, 32'h00FF_00FF);
        write(4'b0001, 32'h0000_0055);
        in_pins = 8'hFF;
        repeat (3) tick();
        rd_check(2'd3, "pre_rst_stat", 32'h00FF_00FF);
        check("pre_rst_out0", 32'(out0), 32'h0000_0055);
        tick();
        check("pre_rst_irq", 32'(irq), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_out0", 32'(out0), 32'd0);
        check("arst_irq",  32'(irq),  32'd0);
        rd_check(2'd3, "arst_stat", 32'd0);
        rd_check(2'd2, "arst_in", 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        rd_check(2'd3, "flag_after_rst", 32'd0);
        tick();
        rd_check(2'd3, "rise_at_release", 32'h0000_00FF);
        tick();
        check("irq_after_rst", 32'(irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
